// File: rtl/sysnet_tx_arbiter.sv
// Packet-granular arbiter sharing the sysnet TX stream between the ack queue
// and two application streams; ack has bounded priority, apps are round-robin.
module sysnet_tx_arbiter #(
  parameter int ACK_BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         resetn,

  input  logic [511:0] s_ack_tdata,
  input  logic [63:0]  s_ack_tkeep,
  input  logic [63:0]  s_ack_tuser,
  input  logic         s_ack_tvalid,
  input  logic         s_ack_tlast,
  output logic         s_ack_tready,

  input  logic [511:0] s_app0_tdata,
  input  logic [63:0]  s_app0_tkeep,
  input  logic [63:0]  s_app0_tuser,
  input  logic         s_app0_tvalid,
  input  logic         s_app0_tlast,
  output logic         s_app0_tready,

  input  logic [511:0] s_app1_tdata,
  input  logic [63:0]  s_app1_tkeep,
  input  logic [63:0]  s_app1_tuser,
  input  logic         s_app1_tvalid,
  input  logic         s_app1_tlast,
  output logic         s_app1_tready,

  output logic [511:0] m_tx_tdata,
  output logic [63:0]  m_tx_tkeep,
  output logic [63:0]  m_tx_tuser,
  output logic         m_tx_tvalid,
  output logic         m_tx_tlast,
  input  logic         m_tx_tready,

  output logic [1:0]   grant,
  output logic         busy,

  output logic         dbg_state,
  output logic         dbg_rr_ptr,
  output logic [7:0]   dbg_ack_burst
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_ACK  = 2'd1;
  localparam logic [1:0] G_APP0 = 2'd2;
  localparam logic [1:0] G_APP1 = 2'd3;

  localparam logic [7:0] BURST_MAX = 8'(ACK_BURST_MAX);
  localparam logic [7:0] BURST_SAT = 8'hff;

  logic [0:0] state;
  logic [1:0] grant_q;
  logic       rr_ptr;
  logic [7:0] ack_burst;

  logic app_any;
  logic ack_win;
  logic pick_app1;
  logic tx_done;

  // Handshake: a beat moves on a rising edge where tvalid and tready are both
  // high; tvalid never waits on tready, and only the granted source sees ready.
  always_comb begin
    app_any   = s_app0_tvalid | s_app1_tvalid;
    ack_win   = s_ack_tvalid && (!app_any || (ack_burst < BURST_MAX));
    pick_app1 = rr_ptr ? s_app1_tvalid : !s_app0_tvalid;
    tx_done   = m_tx_tvalid & m_tx_tready & m_tx_tlast;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      grant_q   <= G_NONE;
      rr_ptr    <= 1'b0;
      ack_burst <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ack_win) begin
            state   <= S_BUSY;
            grant_q <= G_ACK;
            // Only acks that jump ahead of a waiting app count toward the limit.
            if (app_any && (ack_burst != BURST_SAT)) begin
              ack_burst <= ack_burst + 8'd1;
            end
          end else if (app_any) begin
            state     <= S_BUSY;
            grant_q   <= pick_app1 ? G_APP1 : G_APP0;
            rr_ptr    <= !pick_app1;
            ack_burst <= 8'd0;
          end
        end
        S_BUSY: begin
          if (tx_done) begin
            state   <= S_IDLE;
            grant_q <= G_NONE;
          end
        end
        default: begin
          state   <= S_IDLE;
          grant_q <= G_NONE;
        end
      endcase
    end
  end

  // Granted source is passed straight through; everything is zero otherwise.
  always_comb begin
    m_tx_tdata    = '0;
    m_tx_tkeep    = '0;
    m_tx_tuser    = '0;
    m_tx_tvalid   = 1'b0;
    m_tx_tlast    = 1'b0;
    s_ack_tready  = 1'b0;
    s_app0_tready = 1'b0;
    s_app1_tready = 1'b0;
    if (state == S_BUSY) begin
      case (grant_q)
        G_ACK: begin
          m_tx_tdata   = s_ack_tdata;
          m_tx_tkeep   = s_ack_tkeep;
          m_tx_tuser   = s_ack_tuser;
          m_tx_tvalid  = s_ack_tvalid;
          m_tx_tlast   = s_ack_tlast;
          s_ack_tready = m_tx_tready;
        end
        G_APP0: begin
          m_tx_tdata    = s_app0_tdata;
          m_tx_tkeep    = s_app0_tkeep;
          m_tx_tuser    = s_app0_tuser;
          m_tx_tvalid   = s_app0_tvalid;
          m_tx_tlast    = s_app0_tlast;
          s_app0_tready = m_tx_tready;
        end
        G_APP1: begin
          m_tx_tdata    = s_app1_tdata;
          m_tx_tkeep    = s_app1_tkeep;
          m_tx_tuser    = s_app1_tuser;
          m_tx_tvalid   = s_app1_tvalid;
          m_tx_tlast    = s_app1_tlast;
          s_app1_tready = m_tx_tready;
        end
        default: begin
          m_tx_tvalid = 1'b0;
        end
      endcase
    end
  end

  assign grant         = grant_q;
  assign busy          = (state == S_BUSY);
  assign dbg_state     = state;
  assign dbg_rr_ptr    = rr_ptr;
  assign dbg_ack_burst = ack_burst;

endmodule

// File: tb/tb_sysnet_tx_arbiter.sv
// Bench for sysnet_tx_arbiter: packet sources, a cycle-level reference model,
// directed scenarios and grant-order logs checked against hand-derived lists.
module tb_sysnet_tx_arbiter;

  localparam int BURST_MAX = 4;

  // clock / reset
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // stream index: 0 = ack, 1 = app0, 2 = app1 (owner code = index + 1)
  logic [511:0] src_data[3];
  logic [63:0]  src_keep[3];
  logic [63:0]  src_user[3];
  logic         src_valid[3];
  logic         src_last[3];
  logic         src_ready[3];
  logic         m_tx_tready;

  logic [511:0] m_tx_tdata;
  logic [63:0]  m_tx_tkeep, m_tx_tuser;
  logic         m_tx_tvalid, m_tx_tlast;
  logic [1:0]   grant;
  logic         busy, dbg_state, dbg_rr_ptr;
  logic [7:0]   dbg_ack_burst;

  sysnet_tx_arbiter #(.ACK_BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .resetn(resetn),
    .s_ack_tdata(src_data[0]), .s_ack_tkeep(src_keep[0]), .s_ack_tuser(src_user[0]),
    .s_ack_tvalid(src_valid[0]), .s_ack_tlast(src_last[0]), .s_ack_tready(src_ready[0]),
    .s_app0_tdata(src_data[1]), .s_app0_tkeep(src_keep[1]), .s_app0_tuser(src_user[1]),
    .s_app0_tvalid(src_valid[1]), .s_app0_tlast(src_last[1]), .s_app0_tready(src_ready[1]),
    .s_app1_tdata(src_data[2]), .s_app1_tkeep(src_keep[2]), .s_app1_tuser(src_user[2]),
    .s_app1_tvalid(src_valid[2]), .s_app1_tlast(src_last[2]), .s_app1_tready(src_ready[2]),
    .m_tx_tdata(m_tx_tdata), .m_tx_tkeep(m_tx_tkeep), .m_tx_tuser(m_tx_tuser),
    .m_tx_tvalid(m_tx_tvalid), .m_tx_tlast(m_tx_tlast), .m_tx_tready(m_tx_tready),
    .grant(grant), .busy(busy),
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr), .dbg_ack_burst(dbg_ack_burst)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] pay(input int s, input int p, input int b);
    return {16{s[7:0], p[7:0], b[7:0], 8'ha5}};
  endfunction

  // driver: each source sends req[i] packets of len[i] beats
  int req[3]  = '{0, 0, 0};
  int len[3]  = '{1, 1, 1};
  int sent[3] = '{0, 0, 0};
  int beat[3] = '{0, 0, 0};
  logic hs_q[3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (!resetn) begin
        sent[i] = 0;
        beat[i] = 0;
      end else if (hs_q[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          sent[i]++;
        end else begin
          beat[i]++;
        end
      end
      src_valid[i] = (sent[i] < req[i]);
      src_last[i]  = (beat[i] == len[i] - 1);
      src_data[i]  = pay(i, sent[i], beat[i]);
      src_keep[i]  = {8{beat[i][7:0] ^ 8'h3c}};
      src_user[i]  = {i[15:0], sent[i][15:0], beat[i][15:0], 16'hbeef};
    end
  end

  // reference model: who owns the link, preferred app, acks served ahead of apps
  int m_owner = 0;
  int m_rr    = 0;
  int m_burst = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_owner = 0;
      m_rr    = 0;
      m_burst = 0;
    end else if (m_owner == 0) begin
      int apps_waiting;
      int first;
      apps_waiting = int'(src_valid[1]) + int'(src_valid[2]);
      if (src_valid[0] && (apps_waiting == 0 || m_burst < BURST_MAX)) begin
        m_owner = 1;
        if (apps_waiting > 0 && m_burst < 255) m_burst++;
      end else if (apps_waiting > 0) begin
        first = m_rr;
        if (!src_valid[1 + first]) first = 1 - first;
        m_owner = 2 + first;
        m_rr    = 1 - first;
        m_burst = 0;
      end
    end else if (src_valid[m_owner - 1] && m_tx_tready && src_last[m_owner - 1]) begin
      m_owner = 0;
    end
  end

  // scoreboard state
  int cyc = 0;
  logic [1:0] exp_q[$];
  logic [1:0] got_g[$];
  int got_c[$], got_bb[$], got_ba[$], done_c[$];
  logic [1:0] prev_grant = 2'd0;
  int prev_burst = 0;
  logic app_rdy_seen = 1'b0;

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) hs_q[i] = src_valid[i] & src_ready[i];
      check("grant", grant, m_owner);
      check("busy", busy, m_owner != 0);
      check("dbg_state", dbg_state, m_owner != 0);
      check("ack_burst", dbg_ack_burst, m_burst);
      check("rr_ptr", dbg_rr_ptr, m_rr);
      check("tvalid", m_tx_tvalid, m_owner != 0 ? src_valid[m_owner - 1] : 1'b0);
      check("tlast", m_tx_tlast, m_owner != 0 ? src_last[m_owner - 1] : 1'b0);
      check("tdata", m_tx_tdata, m_owner != 0 ? src_data[m_owner - 1] : 512'd0);
      check("tkeep", m_tx_tkeep, m_owner != 0 ? src_keep[m_owner - 1] : 64'd0);
      check("tuser", m_tx_tuser, m_owner != 0 ? src_user[m_owner - 1] : 64'd0);
      for (int i = 0; i < 3; i++)
        check($sformatf("tready%0d", i), src_ready[i], (m_owner == i + 1) && m_tx_tready);
      if (src_ready[1] || src_ready[2]) app_rdy_seen = 1'b1;
      if (grant != 2'd0 && prev_grant == 2'd0) begin
        got_g.push_back(grant);
        got_c.push_back(cyc);
        got_bb.push_back(prev_burst);
        got_ba.push_back(int'(dbg_ack_burst));
      end
      if (m_tx_tvalid && m_tx_tready && m_tx_tlast) done_c.push_back(cyc);
      prev_grant = grant;
      prev_burst = int'(dbg_ack_burst);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) req[i] = 0;
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
    got_g.delete(); got_c.delete(); got_bb.delete(); got_ba.delete(); done_c.delete();
    exp_q.delete();
    app_rdy_seen = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(posedge clk); #2;
      ok = (sent[0] >= req[0]) && (sent[1] >= req[1]) && (sent[2] >= req[2]) && !busy;
    end
    if (!ok) check({tag, "_timeout"}, 1'b1, 1'b0);
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] g);
    bit ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(posedge clk); #2;
      ok = (grant == g);
    end
    if (!ok) check({tag, "_grant_timeout"}, 1'b1, 1'b0);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_count"}, got_g.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_g.size(); i++)
      check($sformatf("%s_grant%0d", tag, i), got_g[i], exp_q[i]);
  endtask

  logic [511:0] stall_data;

  initial begin
    resetn = 1'b0;
    m_tx_tready = 1'b1;
    fork
      compare_loop();
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
      end
    join_none

    // reset state, held low
    repeat (2) @(posedge clk);
    #2;
    check("rst_grant", grant, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_tvalid", m_tx_tvalid, 1'b0);
    check("rst_tdata", m_tx_tdata, 512'd0);

    // ack only: three single-beat packets
    do_reset();
    len[0] = 1; req[0] = 3;
    wait_idle("s1");
    exp_q = '{2'd1, 2'd1, 2'd1};
    check_log("s1");
    if (got_c.size() == 3) begin
      check("s1_gap0", got_c[1] - got_c[0], 2);
      check("s1_gap1", got_c[2] - got_c[1], 2);
    end
    check("s1_app_ready_seen", app_rdy_seen, 1'b0);

    // app round-robin, 2-beat packets
    do_reset();
    len[1] = 2; len[2] = 2; req[1] = 2; req[2] = 2;
    wait_idle("s2");
    exp_q = '{2'd2, 2'd3, 2'd2, 2'd3};
    check_log("s2");
    for (int i = 1; i < got_c.size(); i++)
      check($sformatf("s2_gap%0d", i), got_c[i] - got_c[i - 1], 3);
    check("s2_burst", dbg_ack_burst, 8'd0);

    // starvation limit: acks jump ahead at most four times
    do_reset();
    len[0] = 1; len[1] = 1; req[0] = 10; req[1] = 2;
    wait_idle("s3");
    exp_q = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1};
    check_log("s3");
    if (got_g.size() == 12) begin
      check("s3_burst_before_app_a", got_bb[4], 4);
      check("s3_burst_after_app_a", got_ba[4], 0);
      check("s3_burst_before_app_b", got_bb[9], 4);
      check("s3_burst_after_app_b", got_ba[9], 0);
      check("s3_burst_fourth_ack", got_ba[3], 4);
    end

    // backpressure on app1 beat 2 while ack waits
    do_reset();
    len[2] = 3; req[2] = 1;
    wait_grant("s4", 2'd3);
    len[0] = 1; req[0] = 1;
    @(posedge clk); #2;
    m_tx_tready = 1'b0;
    stall_data = m_tx_tdata;
    check("s4_beat2_data", m_tx_tdata, pay(2, 0, 1));
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #2;
      check($sformatf("s4_stable%0d", n), m_tx_tdata, stall_data);
      check($sformatf("s4_ack_ready%0d", n), src_ready[0], 1'b0);
    end
    m_tx_tready = 1'b1;
    wait_idle("s4");
    exp_q = '{2'd3, 2'd1};
    check_log("s4");
    if (got_c.size() == 2 && done_c.size() >= 1)
      check("s4_bubble", got_c[1] - done_c[0], 2);

    // reset during beat 2 of a 4-beat app0 packet
    do_reset();
    len[1] = 4; req[1] = 1;
    wait_grant("s5", 2'd2);
    @(posedge clk); #2;
    check("s5_pre_tvalid", m_tx_tvalid, 1'b1);
    resetn = 1'b0;
    #1;
    check("s5_tvalid", m_tx_tvalid, 1'b0);
    check("s5_tlast", m_tx_tlast, 1'b0);
    check("s5_grant", grant, 2'd0);
    check("s5_busy", busy, 1'b0);
    check("s5_tdata", m_tx_tdata, 512'd0);
    for (int i = 0; i < 3; i++) check($sformatf("s5_tready%0d", i), src_ready[i], 1'b0);
    do_reset();
    len[1] = 1; len[2] = 1; req[1] = 1; req[2] = 1;
    wait_idle("s5");
    exp_q = '{2'd2, 2'd3};
    check_log("s5");

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
